// File: rtl/seg_pkg.sv
// Shared segment-pattern definitions for the seven-segment display path.
// Patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit). The display
// driver encodes with the same table so both directions stay in agreement.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } seg_state_t;

endpackage

// File: rtl/seg_pattern_lut.sv
// Combinational decode of one 7-bit segment pattern into a digit code.
// Ports:
//   seg_data : sampled pattern {g,f,e,d,c,b,a}, active-low
//   code     : decoded digit 0x0-0xF (0 for blank or unrecognised)
//   blank    : pattern is all segments off
//   err      : pattern is neither a digit nor blank
module seg_pattern_lut
  import seg_pkg::*;
(
  input  logic [6:0] seg_data,
  output logic [3:0] code,
  output logic       blank,
  output logic       err
);

  always_comb begin
    code  = 4'h0;
    blank = 1'b0;
    err   = 1'b0;
    case (seg_data)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_A:     code = 4'hA;
      SEG_B:     code = 4'hB;
      SEG_C:     code = 4'hC;
      SEG_D:     code = 4'hD;
      SEG_E:     code = 4'hE;
      SEG_F:     code = 4'hF;
      SEG_BLANK: blank = 1'b1;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_reader.sv
// Recovers digit codes from sampled seven-segment patterns. A pattern is
// accepted after STABLE_CNT consecutive identical valid samples and emitted
// once on a valid/ready output; results arriving while the output is still
// full are dropped and counted.
//
// state  | meaning
// -------+--------------------------------------------------------------
// EMPTY  | no candidate since reset
// COUNT  | candidate seen cnt times in a row, not yet emitted
// LOCKED | candidate emitted; repeats of it are ignored
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   seg_valid  : seg_data carries a sample this cycle
//   seg_data   : sampled pattern {g,f,e,d,c,b,a}, active-low
//   out_valid  : out_code/out_blank/out_err hold an unconsumed result
//   out_ready  : consumer accepts the result
//   out_code   : decoded digit
//   out_blank  : accepted pattern was blank
//   out_err    : accepted pattern was unrecognised
//   drop_cnt   : saturating count of results lost to a full output
module seg_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seg_valid,
  input  logic [6:0] seg_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_code,
  output logic       out_blank,
  output logic       out_err,
  output logic [7:0] drop_cnt
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  seg_state_t    state, state_n;
  logic [6:0]    cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          emit;

  logic [3:0] lut_code;
  logic       lut_blank;
  logic       lut_err;

  // The emitted sample always equals the candidate, so decoding the live
  // sample avoids a second LUT on the candidate register.
  seg_pattern_lut u_lut (
    .seg_data (seg_data),
    .code     (lut_code),
    .blank    (lut_blank),
    .err      (lut_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      cand  <= SEG_BLANK;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    emit    = 1'b0;
    if (seg_valid) begin
      case (state)
        EMPTY: begin
          cand_n = seg_data;
          cnt_n  = CW'(1);
          if (STABLE_CNT == 1) begin
            emit    = 1'b1;
            state_n = LOCKED;
          end else begin
            state_n = COUNT;
          end
        end
        COUNT: begin
          if (seg_data == cand) begin
            cnt_n = cnt + CW'(1);
            if (cnt + CW'(1) == CW'(STABLE_CNT)) begin
              emit    = 1'b1;
              state_n = LOCKED;
            end
          end else begin
            cand_n = seg_data;
            cnt_n  = CW'(1);
          end
        end
        LOCKED: begin
          if (seg_data != cand) begin
            cand_n = seg_data;
            cnt_n  = CW'(1);
            if (STABLE_CNT == 1) emit = 1'b1;
            else                 state_n = COUNT;
          end
        end
        default: begin
          state_n = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_code  <= 4'h0;
      out_blank <= 1'b0;
      out_err   <= 1'b0;
      drop_cnt  <= 8'd0;
    end else begin
      if (emit && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_code  <= lut_code;
        out_blank <= lut_blank;
        out_err   <= lut_err;
      end else if (emit) begin
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_reader.sv
module tb_seg_reader;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] code;
    logic       blank;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       seg_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [6:0] seg_data4 = 7'h7F;
  logic       out_valid4, out_blank4, out_err4;
  logic [3:0] out_code4;
  logic [7:0] drop_cnt4;

  logic       seg_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [6:0] seg_data1 = 7'h7F;
  logic       out_valid1, out_blank1, out_err1;
  logic [3:0] out_code1;
  logic [7:0] drop_cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out4   = 0;
  int n_out1   = 0;

  vec_t sb4[$];
  vec_t sb1[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  seg_reader #(.STABLE_CNT(4)) dut4 (
    .clk(clk), .rst(rst), .seg_valid(seg_valid4), .seg_data(seg_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_code(out_code4),
    .out_blank(out_blank4), .out_err(out_err4), .drop_cnt(drop_cnt4)
  );

  seg_reader #(.STABLE_CNT(1)) dut1 (
    .clk(clk), .rst(rst), .seg_valid(seg_valid1), .seg_data(seg_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_code(out_code1),
    .out_blank(out_blank1), .out_err(out_err1), .drop_cnt(drop_cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string name, input vec_t e, input logic [3:0] code,
                         input logic blank, input logic err);
    n_checks++;
    if (code != e.code || blank != e.blank || err != e.err) begin
      n_fail++;
      $display("FAIL %s: got code=%0h blank=%0b err=%0b, expected code=%0h blank=%0b err=%0b",
               name, code, blank, err, e.code, e.blank, e.err);
    end
  endtask

  // Scoreboards: every accepted transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      n_out4++;
      if (sb4.size() == 0) begin
        chk("dut4_unexpected_output", {out_code4, out_blank4, out_err4}, -1);
      end else begin
        cmp_out("dut4_result", sb4.pop_front(), out_code4, out_blank4, out_err4);
      end
    end
    if (!rst && out_valid1 && out_ready1) begin
      n_out1++;
      if (sb1.size() == 0) begin
        chk("dut1_unexpected_output", {out_code1, out_blank1, out_err1}, -1);
      end else begin
        cmp_out("dut1_result", sb1.pop_front(), out_code1, out_blank1, out_err1);
      end
    end
  end

  task automatic drive4(input logic [6:0] seg, input logic valid);
    seg_data4  = seg;
    seg_valid4 = valid;
    @(posedge clk);
    #1;
  endtask

  task automatic expect4(input logic [6:0] seg, input logic [3:0] code,
                         input logic blank, input logic err);
    vec_t v;
    v.seg = seg; v.code = code; v.blank = blank; v.err = err;
    sb4.push_back(v);
  endtask

  task automatic chk_reset4(input string tag);
    chk({tag, "_out_valid"}, out_valid4, 0);
    chk({tag, "_out_code"},  out_code4, 0);
    chk({tag, "_out_blank"}, out_blank4, 0);
    chk({tag, "_out_err"},   out_err4, 0);
    chk({tag, "_drop_cnt"},  drop_cnt4, 0);
  endtask

  initial begin
    tbl[0] = '{7'h30, 4'h3, 1'b0, 1'b0};
    tbl[1] = '{7'h19, 4'h4, 1'b0, 1'b0};
    tbl[2] = '{7'h7F, 4'h0, 1'b1, 1'b0};
    tbl[3] = '{7'h7E, 4'h0, 1'b0, 1'b1};
    tbl[4] = '{7'h0E, 4'hF, 1'b0, 1'b0};
    tbl[5] = '{7'h03, 4'hB, 1'b0, 1'b0};
    tbl[6] = '{7'h40, 4'h0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset4("reset");
    chk("reset_dut1_out_valid", out_valid1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic acceptance and latency, then no repeat emissions.
    out_ready4 = 1'b1;
    for (int i = 0; i < 3; i++) drive4(7'h24, 1'b1);
    chk("no_result_before_4th", out_valid4, 0);
    expect4(7'h24, 4'h2, 1'b0, 1'b0);
    drive4(7'h24, 1'b1);
    chk("valid_after_4th", out_valid4, 1);
    for (int i = 0; i < 10; i++) drive4(7'h24, 1'b1);
    chk("single_emit_count", n_out4, 1);

    // Table of stable patterns, each held for four samples.
    foreach (tbl[k]) begin
      for (int i = 0; i < 3; i++) drive4(tbl[k].seg, 1'b1);
      expect4(tbl[k].seg, tbl[k].code, tbl[k].blank, tbl[k].err);
      drive4(tbl[k].seg, 1'b1);
      drive4(tbl[k].seg, 1'b0);
    end

    // Three of one pattern then four of another, with invalid gaps.
    for (int i = 0; i < 3; i++) begin
      drive4(7'h30, 1'b1);
      drive4(7'h24, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect4(7'h19, 4'h4, 1'b0, 1'b0);
      drive4(7'h19, 1'b1);
      drive4(7'h24, 1'b0);
      if (i < 3) chk("gap_no_early_result", out_valid4, 0);
    end
    chk("emit_count_after_gaps", n_out4, 9);

    // Backpressure: second stable result is dropped.
    out_ready4 = 1'b0;
    expect4(7'h79, 4'h1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive4(7'h79, 1'b1);
    for (int i = 0; i < 4; i++) drive4(7'h78, 1'b1);
    chk("held_valid", out_valid4, 1);
    chk("held_code", out_code4, 1);
    chk("drop_one", drop_cnt4, 1);
    seg_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    chk("valid_drops_after_xfer", out_valid4, 0);
    chk("held_xfer_done", sb4.size(), 0);

    // Saturate the drop counter: first result fills the output, rest drop.
    out_ready4 = 1'b0;
    expect4(7'h40, 4'h0, 1'b0, 1'b0);
    for (int r = 0; r < 300; r++) begin
      for (int i = 0; i < 4; i++) drive4((r % 2 == 0) ? 7'h40 : 7'h00, 1'b1);
    end
    chk("drop_saturated", drop_cnt4, 255);
    chk("sat_held_code", out_code4, 0);

    // Reset in the middle of a count while a result is still pending.
    drive4(7'h12, 1'b1);
    drive4(7'h12, 1'b1);
    seg_valid4 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset4("midreset");
    sb4.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready4 = 1'b1;
    for (int i = 0; i < 3; i++) drive4(7'h12, 1'b1);
    chk("post_reset_no_early", out_valid4, 0);
    expect4(7'h12, 4'h5, 1'b0, 1'b0);
    drive4(7'h12, 1'b1);
    chk("post_reset_valid", out_valid4, 1);
    drive4(7'h12, 1'b0);
    seg_valid4 = 1'b0;

    // STABLE_CNT=1: alternating patterns emit every cycle, back to back.
    out_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.seg   = (i % 2 == 0) ? 7'h40 : 7'h00;
      v.code  = (i % 2 == 0) ? 4'h0 : 4'h8;
      v.blank = 1'b0;
      v.err   = 1'b0;
      sb1.push_back(v);
      seg_data1  = v.seg;
      seg_valid1 = 1'b1;
      @(posedge clk); #1;
      chk("sc1_valid_each_cycle", out_valid1, 1);
    end
    seg_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("sc1_no_drops", drop_cnt1, 0);
    chk("sc1_result_count", n_out1, 8);
    chk("sc1_sb_empty", sb1.size(), 0);
    chk("dut4_sb_empty", sb4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_reader.md
# seg_reader

Reverse path of the seven-segment display driver: accepts sampled 7-bit segment patterns, for example per-digit segment-activation vectors from the numeral recognition front end, and recovers the 4-bit digit code. A pattern is accepted only after it has been seen on STABLE_CNT consecutive valid samples. Each stable pattern is emitted once on a valid/ready output, with explicit flags for blank and unrecognised patterns. It sits between the segment sampler and the number-assembly/result logic.

## Interface
- STABLE_CNT, 4: consecutive identical valid samples required before a pattern is accepted; legal range 1..15.
- clk  in  1: system clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- seg_valid  in  1: seg_data carries a sample this cycle.
- seg_data  in  7: pattern {g,f,e,d,c,b,a}, active-low (0 = segment lit), same encoding the display driver produces.
- out_valid  out  1: out_code/out_err/out_blank hold an unconsumed result.
- out_ready  in  1: consumer accepts the result when high with out_valid.
- out_code  out  4: decoded digit, 0x0–0xF.
- out_blank  out  1: accepted pattern was all-off (7'h7F).
- out_err  out  1: accepted pattern matches no digit and is not blank.
- drop_cnt  out  8: saturating count of stable results lost because the output was still full.

## Operation
- Decode map (pattern → code): 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F.
- Pattern 0x7F: out_blank=1, out_code=0, out_err=0.
- Any other pattern: out_err=1, out_code=0, out_blank=0.
- Registers: cand[6:0] holds the candidate pattern. cnt holds the count of consecutive identical samples and is $clog2(STABLE_CNT+1) bits wide.
- States:
  - EMPTY: no candidate. Any valid sample loads cand and sets cnt=1, then → COUNT, or emits immediately and → LOCKED if STABLE_CNT==1.
  - COUNT, valid sample equal to cand: cnt+1. When cnt+1 reaches STABLE_CNT, emit and → LOCKED.
  - COUNT, valid sample differing from cand: cand=sample, cnt=1, stay in COUNT.
  - LOCKED: pattern already emitted. An equal sample does nothing, so there are no repeat emissions. A differing sample sets cand=sample and cnt=1, then → COUNT, or emits and stays LOCKED if STABLE_CNT==1.
- seg_valid low: no state change; counts are neither advanced nor cleared.
- Emit with the output empty (out_valid=0), or with out_valid&&out_ready in the same cycle: load the output registers and set out_valid=1.
- Emit while out_valid=1 and out_ready=0: the new result is discarded, the held result is unchanged, and drop_cnt increments, saturating at 255.
- out_valid&&out_ready with no emit: out_valid → 0. The data registers keep their last values.

## Timing
- Reset values: state=EMPTY, cand=7'h7F, cnt=0, out_valid=0, out_code=0, out_blank=0, out_err=0, drop_cnt=0.
- Latency: out_valid rises on the clock edge that captures the STABLE_CNT-th identical sample. It is visible in the following cycle, one cycle after that sample is presented.
- Output data is stable while out_valid=1 and out_ready=0.
- Back-to-back transfers are supported: with out_ready held high, consecutive emits give consecutive results with no bubble.
- Asserting rst mid-count or mid-handshake immediately clears all state. A pending result is lost and is not counted as a drop.

## Structure
- Package seg_pkg holds:
  - localparams SEG_0..SEG_F and SEG_BLANK (7'h7F), shared with the display driver so both directions use one table;
  - the state enum {EMPTY, COUNT, LOCKED}.
- Sub-module seg_pattern_lut: purely combinational, seg_data[6:0] → {code[3:0], blank, err}. It is instantiated once, on the sample path.
- The top-level seg_reader contains the stability FSM, the output register, and the drop counter.

## Test plan
- STABLE_CNT=4, with 0x24 presented on 4 consecutive valid cycles and out_ready=1 → exactly one result: out_code=2, out_err=0, out_blank=0, with out_valid one cycle after the 4th sample. Continuing with 0x24 for 10 more cycles → no further results.
- Sequence 0x30,0x30,0x30,0x19,0x19,0x19,0x19 → no result for 3; one result out_code=4. Gaps with seg_valid=0 between samples do not change this.
- Four samples of 0x7F → out_blank=1. Four samples of 0x7E → out_err=1, out_code=0.
- out_ready=0, stable 0x79 then stable 0x78 → out_code stays 1, drop_cnt=1. Then out_ready=1 → the transfer completes and out_valid drops.
- 300 dropped results → drop_cnt saturates at 255. Assert rst mid-count (cnt=2) → all outputs return to reset values, and the next result needs a full 4 samples.
- STABLE_CNT=1, alternating 0x40/0x00 every cycle with out_ready=1 → results 0,8,0,8… on every cycle with no drops.
